// File: rtl/uart_pkg.sv
// Shared definitions for the UART register bank and its response serializer.
// Holds command codes, response frame constants and the response FSM encoding.
package uart_pkg;

    // Command codes carried in func_reg
    localparam logic [7:0] CMD_WRITE  = 8'h01;  // load a channel's shadow set
    localparam logic [7:0] CMD_EN     = 8'h02;  // load a channel's shadow enable
    localparam logic [7:0] CMD_COMMIT = 8'h03;  // shadow -> active for a channel mask
    localparam logic [7:0] CMD_READ   = 8'h04;  // read back a channel's active set

    // Response frame constants
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] NACK_CODE = 8'hEE;
    localparam int         READ_LEN  = 12;
    localparam int         NACK_LEN  = 3;
    localparam int         FRAME_MAX = 12;

    // Response serializer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response serializer: captures a readback or NACK frame into a byte buffer
// and streams it out over a valid/ready byte interface.
//
// Ports
//   clk_50M, rst         clock, synchronous active-high reset
//   start                one-cycle request, only honoured in IDLE
//   start_nack           request is a NACK (else a readback)
//   start_ch, start_func channel and command of the request
//   sel_ch               latched channel, used by the parent to mux rd_*
//   rd_duty .. rd_pat    active register values of sel_ch (pattern zero-extended)
//   tx_data/valid/ready  response byte stream
//   busy                 response in progress (state != IDLE)
//   state_dbg            current FSM state
//
// Handshake: tx_valid is high for every cycle in SEND; a byte is transferred
// on a rising edge where tx_valid && tx_ready. tx_data holds its value until
// that transfer and presents the next byte on the following cycle.
module uart_resp_tx
    import uart_pkg::*;
(
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        start,
    input  logic        start_nack,
    input  logic [7:0]  start_ch,
    input  logic [7:0]  start_func,
    output logic [7:0]  sel_ch,
    input  logic [7:0]  rd_duty,
    input  logic [15:0] rd_dessert,
    input  logic [7:0]  rd_pulse,
    input  logic [31:0] rd_pat,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    tx_state_t  state, state_nxt;
    logic [7:0] frame_buf [FRAME_MAX];
    logic [3:0] idx, last_idx;
    logic       nack_q;
    logic [7:0] func_q, ch_q;
    logic [7:0] rb    [FRAME_MAX];
    logic [7:0] csum;
    logic       last_xfer;

    assign sel_ch    = ch_q;
    assign state_dbg = state;
    assign last_xfer = (state == ST_SEND) && tx_ready && (idx == last_idx);

    // Readback frame assembled from the live active registers; it is only
    // sampled into frame_buf during LOAD, so later commits cannot reach it.
    always_comb begin
        rb[0]  = FRAME_HDR;
        rb[1]  = CMD_READ;
        rb[2]  = ch_q;
        rb[3]  = rd_duty;
        rb[4]  = rd_dessert[15:8];
        rb[5]  = rd_dessert[7:0];
        rb[6]  = rd_pulse;
        rb[7]  = rd_pat[31:24];
        rb[8]  = rd_pat[23:16];
        rb[9]  = rd_pat[15:8];
        rb[10] = rd_pat[7:0];
        csum   = 8'h00;
        for (int i = 0; i < READ_LEN - 1; i++) csum = csum ^ rb[i];
        rb[11] = csum;
    end

    // State register
    always_ff @(posedge clk_50M) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (last_xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx_valid = (state == ST_SEND);
        tx_data  = (state == ST_SEND) ? frame_buf[idx] : 8'h00;
        busy     = (state != ST_IDLE);
    end

    // Request latch, frame buffer and byte pointer
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            nack_q   <= 1'b0;
            func_q   <= 8'h00;
            ch_q     <= 8'h00;
            idx      <= 4'd0;
            last_idx <= 4'd0;
            for (int i = 0; i < FRAME_MAX; i++) frame_buf[i] <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nack_q <= start_nack;
                        func_q <= start_func;
                        ch_q   <= start_ch;
                    end
                end
                ST_LOAD: begin
                    idx <= 4'd0;
                    if (nack_q) begin
                        last_idx <= 4'(NACK_LEN - 1);
                        for (int i = 0; i < FRAME_MAX; i++) frame_buf[i] <= 8'h00;
                        frame_buf[0] <= FRAME_HDR;
                        frame_buf[1] <= NACK_CODE;
                        frame_buf[2] <= func_q;
                    end else begin
                        last_idx <= 4'(READ_LEN - 1);
                        for (int i = 0; i < FRAME_MAX; i++) frame_buf[i] <= rb[i];
                    end
                end
                ST_SEND: begin
                    if (tx_ready) idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_bank.sv
// Per-channel PWM/DAC register bank driven by decoded UART packets.
// Each channel has a shadow set (written by commands) and an active set
// (driving the outputs); a commit copies shadow to active atomically.
//
// Ports
//   clk_50M, rst      clock, synchronous active-high reset
//   func_reg          command code of the received packet
//   rev_data          payload bytes 1..10 (byte1 in [79:72])
//   pack_done         one-cycle packet-valid pulse
//   tx_data/valid/ready  response byte stream
//   ch_en, duty_num, pulse_dessert, pulse_num, pat  active registers, ch0 in LSBs
//   err_cnt           saturating error counter
//   busy              response in progress
module uart_reg_bank
    import uart_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PAT_W  = 32,
    parameter int DUTY_W = 8
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic [7:0]               func_reg,
    input  logic [79:0]              rev_data,
    input  logic                     pack_done,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH*DUTY_W-1:0] duty_num,
    output logic [NUM_CH*16-1:0]     pulse_dessert,
    output logic [NUM_CH*DUTY_W-1:0] pulse_num,
    output logic [NUM_CH*PAT_W-1:0]  pat,
    output logic [7:0]               err_cnt,
    output logic                     busy
);

    logic [7:0]  b1, b2;
    logic        is_err, is_read, resp_start, err_inc;
    logic [7:0]  sel_ch;
    logic [7:0]  rd_duty, rd_pulse;
    logic [15:0] rd_dessert;
    logic [31:0] rd_pat;
    logic [1:0]  unused_tx_state;
    logic        unused_rev;

    logic              sh_en     [NUM_CH];
    logic [DUTY_W-1:0] sh_duty   [NUM_CH];
    logic [15:0]       sh_des    [NUM_CH];
    logic [DUTY_W-1:0] sh_pulse  [NUM_CH];
    logic [PAT_W-1:0]  sh_pat    [NUM_CH];
    logic              act_en    [NUM_CH];
    logic [DUTY_W-1:0] act_duty  [NUM_CH];
    logic [15:0]       act_des   [NUM_CH];
    logic [DUTY_W-1:0] act_pulse [NUM_CH];
    logic [PAT_W-1:0]  act_pat   [NUM_CH];

    assign b1         = rev_data[79:72];
    assign b2         = rev_data[71:64];
    assign unused_rev = ^rev_data;

    // Decode. Commit carries a mask rather than a channel, so only the
    // channel-addressed commands range-check byte1.
    always_comb begin
        is_read = (func_reg == CMD_READ);
        is_err  = (func_reg < CMD_WRITE) || (func_reg > CMD_READ) ||
                  ((func_reg != CMD_COMMIT) && (b1 >= 8'(NUM_CH)));
        // A response is only queued when the serializer is idle; a readback
        // or error arriving while busy is dropped and counted as an error.
        resp_start = pack_done && !busy && (is_err || is_read);
        err_inc    = pack_done && (is_err || (is_read && busy));
    end

    // Register file: write/enable/commit still execute while busy.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_en[i]     <= 1'b0;
                sh_duty[i]   <= '0;
                sh_des[i]    <= '0;
                sh_pulse[i]  <= '0;
                sh_pat[i]    <= '0;
                act_en[i]    <= 1'b0;
                act_duty[i]  <= '0;
                act_des[i]   <= '0;
                act_pulse[i] <= '0;
                act_pat[i]   <= '0;
            end
        end else if (pack_done && !is_err) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (func_reg == CMD_WRITE && b1 == 8'(i)) begin
                    sh_duty[i]  <= DUTY_W'(rev_data[63:56]);
                    sh_des[i]   <= rev_data[55:40];
                    sh_pulse[i] <= DUTY_W'(rev_data[39:32]);
                    sh_pat[i]   <= rev_data[PAT_W-1:0];
                end
                if (func_reg == CMD_EN && b1 == 8'(i))
                    sh_en[i] <= b2[0];
                if (func_reg == CMD_COMMIT && b2[i]) begin
                    act_en[i]    <= sh_en[i];
                    act_duty[i]  <= sh_duty[i];
                    act_des[i]   <= sh_des[i];
                    act_pulse[i] <= sh_pulse[i];
                    act_pat[i]   <= sh_pat[i];
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst)                            err_cnt <= 8'h00;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end

    // Flatten active set onto the output buses, channel 0 in the LSBs
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_en[i]                          = act_en[i];
            duty_num[i*DUTY_W +: DUTY_W]      = act_duty[i];
            pulse_dessert[i*16 +: 16]         = act_des[i];
            pulse_num[i*DUTY_W +: DUTY_W]     = act_pulse[i];
            pat[i*PAT_W +: PAT_W]             = act_pat[i];
        end
    end

    // Readback source for the channel latched by the serializer
    always_comb begin
        rd_duty    = 8'h00;
        rd_dessert = 16'h0000;
        rd_pulse   = 8'h00;
        rd_pat     = 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == 8'(i)) begin
                rd_duty    = act_duty[i][7:0];
                rd_dessert = act_des[i];
                rd_pulse   = act_pulse[i][7:0];
                rd_pat     = 32'(act_pat[i]);
            end
        end
    end

    uart_resp_tx u_resp_tx (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .start      (resp_start),
        .start_nack (is_err),
        .start_ch   (b1),
        .start_func (func_reg),
        .sel_ch     (sel_ch),
        .rd_duty    (rd_duty),
        .rd_dessert (rd_dessert),
        .rd_pulse   (rd_pulse),
        .rd_pat     (rd_pat),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .state_dbg  (unused_tx_state)
    );

endmodule
